// File: rtl/box_drawer_if.sv
// Position-update handshake between a location processor (master) and a box_drawer (slave).
// One (x, y, colour) update is transferred per edge with s_valid && s_ready.
interface box_drawer_if;
  logic       s_valid;
  logic       s_ready;
  logic [8:0] s_x;
  logic [8:0] s_y;
  logic [2:0] s_color;

  modport master (
    output s_valid,
    output s_x,
    output s_y,
    output s_color,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_x,
    input  s_y,
    input  s_color,
    output s_ready
  );
endinterface

// File: rtl/box_drawer.sv
// Moving-object pixel writer: erases the previously drawn rectangle in the background colour,
// then draws the rectangle at the newly accepted position, one pixel per clock.
module box_drawer #(
  parameter logic [8:0] BOX_WIDTH     = 9'd10,
  parameter logic [8:0] BOX_HEIGHT    = 9'd48,
  parameter logic [8:0] SCREEN_WIDTH  = 9'd320,
  parameter logic [8:0] SCREEN_HEIGHT = 9'd240,
  parameter logic [2:0] BG_COLOR      = 3'b000
) (
  input  logic         clock,
  input  logic         reset_n,
  box_drawer_if.slave  s_if,
  output logic [8:0]   vga_x,
  output logic [7:0]   vga_y,
  output logic [2:0]   vga_color,
  output logic         vga_plot,
  output logic         done
);

  typedef enum logic [1:0] {StIdle, StErase, StDraw} state_e;

  state_e     state_q;
  logic [8:0] col_q, row_q;
  logic [8:0] prev_x_q, prev_y_q;
  logic [8:0] new_x_q, new_y_q;
  logic [2:0] new_color_q;
  logic       has_prev_q;
  logic       done_q;

  logic       last_col, last_row;
  logic [9:0] base_x, base_y, sum_x, sum_y;
  logic [2:0] pix_color;

  assign last_col    = (col_q == BOX_WIDTH - 9'd1);
  assign last_row    = (row_q == BOX_HEIGHT - 9'd1);
  assign s_if.s_ready = (state_q == StIdle);
  assign done        = done_q;

  // Sums are 10 bits wide so off-screen pixels are detected before truncation.
  always_comb begin
    base_x    = {1'b0, new_x_q};
    base_y    = {1'b0, new_y_q};
    pix_color = new_color_q;
    if (state_q == StErase) begin
      base_x    = {1'b0, prev_x_q};
      base_y    = {1'b0, prev_y_q};
      pix_color = BG_COLOR;
    end
    sum_x = base_x + {1'b0, col_q};
    sum_y = base_y + {1'b0, row_q};

    vga_x     = 9'd0;
    vga_y     = 8'd0;
    vga_color = 3'd0;
    vga_plot  = 1'b0;
    if (state_q != StIdle) begin
      vga_x     = sum_x[8:0];
      vga_y     = sum_y[7:0];
      vga_color = pix_color;
      vga_plot  = (sum_x < {1'b0, SCREEN_WIDTH}) && (sum_y < {1'b0, SCREEN_HEIGHT});
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      col_q       <= 9'd0;
      row_q       <= 9'd0;
      prev_x_q    <= 9'd0;
      prev_y_q    <= 9'd0;
      new_x_q     <= 9'd0;
      new_y_q     <= 9'd0;
      new_color_q <= 3'd0;
      has_prev_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (s_if.s_valid) begin
            new_x_q     <= s_if.s_x;
            new_y_q     <= s_if.s_y;
            new_color_q <= s_if.s_color;
            col_q       <= 9'd0;
            row_q       <= 9'd0;
            state_q     <= has_prev_q ? StErase : StDraw;
          end
        end
        StErase, StDraw: begin
          if (last_col) begin
            col_q <= 9'd0;
            if (last_row) begin
              row_q <= 9'd0;
              if (state_q == StErase) begin
                state_q <= StDraw;
              end else begin
                state_q    <= StIdle;
                prev_x_q   <= new_x_q;
                prev_y_q   <= new_y_q;
                has_prev_q <= 1'b1;
                done_q     <= 1'b1;
              end
            end else begin
              row_q <= row_q + 9'd1;
            end
          end else begin
            col_q <= col_q + 9'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_box_drawer.sv
// Bench for box_drawer: a 3x2 instance checked pixel-by-pixel against a rectangle model,
// and a default-size instance checked for plot-cycle and done-pulse counts.
module tb_box_drawer;

  localparam int         WI = 3;
  localparam int         HI = 2;
  localparam logic [2:0] BG = 3'b011;
  localparam int         NBIG = 10 * 48;

  logic clock;
  logic reset_n;

  box_drawer_if s_sm ();
  box_drawer_if s_big ();

  logic [8:0] sm_vx, big_vx;
  logic [7:0] sm_vy, big_vy;
  logic [2:0] sm_vc, big_vc;
  logic       sm_plot, big_plot, sm_done, big_done;

  box_drawer #(
    .BOX_WIDTH    (9'(WI)),
    .BOX_HEIGHT   (9'(HI)),
    .SCREEN_WIDTH (9'd320),
    .SCREEN_HEIGHT(9'd240),
    .BG_COLOR     (BG)
  ) u_sm (
    .clock    (clock),
    .reset_n  (reset_n),
    .s_if     (s_sm),
    .vga_x    (sm_vx),
    .vga_y    (sm_vy),
    .vga_color(sm_vc),
    .vga_plot (sm_plot),
    .done     (sm_done)
  );

  box_drawer u_big (
    .clock    (clock),
    .reset_n  (reset_n),
    .s_if     (s_big),
    .vga_x    (big_vx),
    .vga_y    (big_vy),
    .vga_color(big_vc),
    .vga_plot (big_plot),
    .done     (big_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Model of what is currently on screen for the small instance.
  bit has_prev_m = 1'b0;
  int prev_x_m   = 0;
  int prev_y_m   = 0;

  typedef struct packed {
    logic       p;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void add_rect(input int bx, input int by, input logic [2:0] col);
    for (int r = 0; r < HI; r++) begin
      for (int c = 0; c < WI; c++) begin
        pix_t p;
        int   x;
        int   y;
        x   = bx + c;
        y   = by + r;
        p.p = (x < 320) && (y < 240);
        p.x = 9'(x);
        p.y = 8'(y);
        p.c = col;
        exp_q.push_back(p);
      end
    end
  endfunction

  // One update on the small instance. hold keeps s_valid high and scrambles s_x while busy;
  // abort_at >= 0 pulses reset_n low asynchronously while that pixel is being presented.
  task automatic run_update(input int x, input int y, input logic [2:0] col, input bit hold,
                            input int abort_at);
    logic [22:0] got;
    logic [22:0] expv;
    chk("ready_before", 32'(s_sm.s_ready), 32'd1);
    s_sm.s_valid = 1'b1;
    s_sm.s_x     = 9'(x);
    s_sm.s_y     = 9'(y);
    s_sm.s_color = col;
    exp_q.delete();
    if (has_prev_m) add_rect(prev_x_m, prev_y_m, BG);
    add_rect(x, y, col);
    @(posedge clock);
    #1;
    if (!hold) s_sm.s_valid = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (hold) s_sm.s_x = 9'($urandom);
      if (i == abort_at) begin
        #2;
        chk("pre_abort_plot", 32'(sm_plot), 32'(exp_q[i].p));
        reset_n = 1'b0;
        #1;
        chk("abort_plot", 32'(sm_plot), 32'd0);
        chk("abort_ready", 32'(s_sm.s_ready), 32'd1);
        s_sm.s_valid = 1'b0;
        @(negedge clock);
        #2;
        reset_n    = 1'b1;
        has_prev_m = 1'b0;
        return;
      end
      @(negedge clock);
      got  = {sm_plot, sm_vx, sm_vy, sm_vc, s_sm.s_ready, sm_done};
      expv = {exp_q[i], 2'b00};
      chk("pixel", 32'(got), 32'(expv));
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    chk("done_cycle", 32'({sm_plot, s_sm.s_ready, sm_done}), 32'b011);
    prev_x_m   = x;
    prev_y_m   = y;
    has_prev_m = 1'b1;
  endtask

  task automatic idle_check();
    @(posedge clock);
    #1;
    chk("idle", 32'({sm_plot, s_sm.s_ready, sm_done, sm_vx, sm_vy, sm_vc}),
        32'({1'b0, 1'b1, 1'b0, 9'd0, 8'd0, 3'd0}));
  endtask

  task automatic big_update(input int n);
    int plots;
    int dones;
    int done_at;
    plots   = 0;
    dones   = 0;
    done_at = -1;
    s_big.s_valid = 1'b1;
    s_big.s_x     = 9'd10;
    s_big.s_y     = 9'd0;
    s_big.s_color = 3'($urandom);
    @(posedge clock);
    #1;
    s_big.s_valid = 1'b0;
    for (int i = 0; i < n + 4; i++) begin
      @(negedge clock);
      plots += int'(big_plot);
      if (big_done) begin
        dones++;
        done_at = i;
      end
    end
    chk("big_plots", 32'(plots), 32'(n));
    chk("big_dones", 32'(dones), 32'd1);
    chk("big_done_at", 32'(done_at), 32'(n));
    chk("big_ready", 32'(s_big.s_ready), 32'd1);
  endtask

  initial begin
    reset_n       = 1'b0;
    s_sm.s_valid  = 1'b0;
    s_sm.s_x      = 9'd0;
    s_sm.s_y      = 9'd0;
    s_sm.s_color  = 3'd0;
    s_big.s_valid = 1'b0;
    s_big.s_x     = 9'd0;
    s_big.s_y     = 9'd0;
    s_big.s_color = 3'd0;
    #12;
    chk("reset_sm", 32'({sm_plot, s_sm.s_ready, sm_done, sm_vx, sm_vy, sm_vc}),
        32'({1'b0, 1'b1, 1'b0, 9'd0, 8'd0, 3'd0}));
    chk("reset_big", 32'({big_plot, s_big.s_ready, big_done, big_vx, big_vy, big_vc}),
        32'({1'b0, 1'b1, 1'b0, 9'd0, 8'd0, 3'd0}));
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    run_update(5, 7, 3'b100, 1'b0, -1);
    idle_check();
    run_update(6, 7, 3'b010, 1'b0, -1);
    idle_check();
    run_update(318, 239, 3'b111, 1'b0, -1);
    idle_check();
    run_update(1, 1, 3'b000, 1'b1, -1);
    run_update(100, 50, 3'b101, 1'b0, -1);
    idle_check();

    for (int k = 0; k < 10; k++) begin
      int rx;
      int ry;
      rx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(314, 330)) : int'($urandom_range(0, 511));
      ry = ($urandom_range(0, 2) == 0) ? int'($urandom_range(236, 258)) : int'($urandom_range(0, 511));
      run_update(rx, ry, 3'($urandom), 1'b0, -1);
      if (k % 2 == 0) idle_check();
    end
    idle_check();

    run_update(20, 20, 3'b110, 1'b0, 2);
    @(negedge clock);
    run_update(30, 30, 3'b001, 1'b0, -1);
    idle_check();

    big_update(NBIG);
    big_update(2 * NBIG);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
